if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Takes redirect requests from EX (branch comparator `br`, jal, jalr). Branches resolve in EX, so the two younger instructions are squashed on a redirect.
- Drives the instruction-memory address and raises the flush to ID/EX.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- NOP, 32'h0000_0013, instruction word injected into IF/ID on flush or bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_if  in  1  hazard unit: hold PC.
- stall_id  in  1  hazard unit: hold IF/ID.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_br  in  1  branch-taken flag from the EX branch comparator.
- ex_jal  in  1  EX instruction is jal.
- ex_jalr  in  1  EX instruction is jalr.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended immediate of the EX instruction.
- ex_rs1  in  32  forwarded rs1 value in EX.
- imem_addr  out  32  instruction-memory address, equal to pc_if; memory read is combinational.
- imem_rdata  in  32  instruction word at imem_addr.
- pc_if  out  32  current PC.
- inst_id  out  32  IF/ID instruction.
- pc_id  out  32  IF/ID PC.
- pc4_id  out  32  IF/ID PC+4.
- valid_id  out  1  IF/ID holds a real instruction.
- flush_id_ex  out  1  combinational; clears ID/EX this cycle.
- misalign_err  out  1  sticky misaligned-target flag.
- redirect_cnt  out  32  count of taken redirects.

Behaviour:
- Reset (async, immediate):
  - pc_if = PC_RESET
  - inst_id = NOP, pc_id = 0, pc4_id = 0, valid_id = 0
  - misalign_err = 0, redirect_cnt = 0
- redirect = ex_valid & (ex_br | ex_jal | ex_jalr).
- Target selection, priority jalr > jal > br (decoder never asserts two at once; the priority is fixed anyway):
  - jalr: (ex_rs1 + ex_imm) & ~32'h1
  - jal or br: ex_pc + ex_imm
  - All adds are 32-bit modulo 2^32.
- Misaligned target (target[1] = 1): PC loads {target[31:2], 2'b00} and misalign_err sets. misalign_err stays set until rst.
- Next PC, priority order:
  - redirect: target. Redirect overrides stall_if.
  - stall_if: hold.
  - otherwise: pc_if + 4, wrapping 32'hFFFF_FFFC -> 32'h0.
- IF/ID update, priority order:
  - redirect: inst_id = NOP, valid_id = 0, pc_id = 0, pc4_id = 0. Overrides stall_id.
  - stall_id: hold all fields.
  - stall_if = 1 and stall_id = 0: bubble (NOP, valid_id = 0, pc fields 0).
  - otherwise: inst_id = imem_rdata, pc_id = pc_if, pc4_id = pc_if + 4, valid_id = 1.
- flush_id_ex = redirect, same cycle, combinational.
- Redirect penalty: 2 cycles. The instructions in IF and ID at redirect time never reach EX.
- redirect_cnt increments by 1 on each clock edge where redirect = 1 and wraps at 2^32. Stalls do not affect it.
- Fetch latency: an instruction is visible in inst_id one clock after its pc_if cycle.
- Reset mid-stall or mid-redirect: reset wins; the first fetch after release is from PC_RESET.

Test Plan:
- Reset then free-run 4 cycles, imem returning 0xA, 0xB, 0xC, 0xD -> pc_if = 3000, 3004, 3008, 300C; inst_id lags by one cycle; valid_id = 1 from cycle 2.
- Branch redirect: ex_valid = 1, ex_br = 1, ex_pc = 0x3008, ex_imm = 0xFFFFFFF8 -> flush_id_ex = 1 that cycle; next pc_if = 0x3000; inst_id = NOP, valid_id = 0; redirect_cnt = 1.
- jalr: ex_rs1 = 0x4001, ex_imm = 4, ex_jalr = 1, ex_br = 1 together -> pc_if = 0x4004 (jalr wins, bit 0 cleared); misalign_err stays 0.
- Stall interaction:
  - stall_if = stall_id = 1 for 3 cycles -> pc_if and IF/ID frozen.
  - stall_if = 1, stall_id = 0 -> valid_id = 0, inst_id = NOP.
  - stall_if = 1 and redirect same cycle -> PC takes the target.
- Misaligned target: ex_jal = 1, ex_pc = 0x3000, ex_imm = 0x6 -> pc_if = 0x3004; misalign_err = 1 and stays 1 after 10 more cycles; cleared only by rst.
- Wrap and async reset: pc_if = 0xFFFFFFFC, no stall -> next pc_if = 0x0. Assert rst mid-cycle -> pc_if = 0x3000 before the next clock edge; redirect_cnt = 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Holds the PC and the IF/ID pipeline register. It accepts redirects resolved
// in EX and raises a same-cycle flush toward ID/EX. It also keeps a sticky
// misaligned-target flag and a count of taken redirects.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        ex_valid,
  input  logic        ex_br,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc4_id,
  output logic        valid_id,
  output logic        flush_id_ex,
  output logic        misalign_err,
  output logic [31:0] redirect_cnt
);

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        target_misaligned;
  logic [31:0] pc_plus4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] cnt_q, cnt_d;

  // Redirect detection and target computation. jalr takes priority over jal
  // and br, even if the decoder ever asserts more than one of them.
  always_comb begin
    redirect = ex_valid & (ex_br | ex_jal | ex_jalr);
    if (ex_jalr) begin
      target_raw = (ex_rs1 + ex_imm) & ~32'h1;
    end else begin
      target_raw = ex_pc + ex_imm;
    end
    // A target with bit 1 set is forced down to a word boundary and flagged.
    target_misaligned = target_raw[1];
    target            = target_misaligned ? {target_raw[31:2], 2'b00} : target_raw;
    pc_plus4          = pc_q + 32'd4;
  end

  // Next-state selection for the PC, the IF/ID fields, the error flag and the counter.
  always_comb begin
    // PC: a redirect overrides a stall. Otherwise a stall holds the PC, and
    // without a stall the PC advances by 4 and wraps modulo 2^32.
    if (redirect) begin
      pc_d = target;
    end else if (stall_if) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4;
    end

    // IF/ID: a flush overrides a hold. Otherwise a hold keeps the register.
    // Without a hold, a stalled fetch injects a bubble and a normal fetch
    // captures the instruction.
    inst_d   = NOP;
    pc_id_d  = 32'h0;
    pc4_id_d = 32'h0;
    valid_d  = 1'b0;
    if (redirect) begin
      inst_d   = NOP;
      pc_id_d  = 32'h0;
      pc4_id_d = 32'h0;
      valid_d  = 1'b0;
    end else if (stall_id) begin
      inst_d   = inst_q;
      pc_id_d  = pc_id_q;
      pc4_id_d = pc4_id_q;
      valid_d  = valid_q;
    end else if (stall_if) begin
      inst_d   = NOP;
      pc_id_d  = 32'h0;
      pc4_id_d = 32'h0;
      valid_d  = 1'b0;
    end else begin
      inst_d   = imem_rdata;
      pc_id_d  = pc_q;
      pc4_id_d = pc_plus4;
      valid_d  = 1'b1;
    end

    // The misaligned flag is sticky until reset. The counter wraps naturally.
    misalign_d = misalign_q | (redirect & target_misaligned);
    cnt_d      = redirect ? cnt_q + 32'd1 : cnt_q;
  end

  // State registers with immediate asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= PC_RESET;
      inst_q     <= NOP;
      pc_id_q    <= 32'h0;
      pc4_id_q   <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output mapping. The flush is combinational, so ID/EX clears in the redirect cycle.
  always_comb begin
    imem_addr    = pc_q;
    pc_if        = pc_q;
    inst_id      = inst_q;
    pc_id        = pc_id_q;
    pc4_id       = pc4_id_q;
    valid_id     = valid_q;
    flush_id_ex  = redirect;
    misalign_err = misalign_q;
    redirect_cnt = cnt_q;
  end

endmodule
